// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Winner select for the shared port: data requester has priority until fetch
// has lost STARVE_MAX consecutive arbitrations, then fetch wins once.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid,
  input  logic dm_valid,
  input  logic grant_if,
  input  logic grant_dm,
  output logic pick_if
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign pick_if = if_valid && !(dm_valid && (cnt_q < CW'(STARVE_MAX)));

  // Holds while fetch waits outside IDLE; only a fetch loss to dm counts.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_valid || grant_if) begin
      cnt_d = '0;
    end else if (grant_dm && (cnt_q < CW'(STARVE_MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency external memory port between the fetch and the
// data-memory requesters; one access in flight, response routed to its owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              dm_req_valid,
  input  logic              dm_req_we,
  input  logic [ADDR_W-1:0] dm_req_addr,
  input  logic [DATA_W-1:0] dm_req_wdata,
  output logic              dm_req_ready,
  output logic              dm_rsp_valid,
  output logic [DATA_W-1:0] dm_rsp_data,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_we,
  input  logic [DATA_W-1:0] ext_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  lat_q, lat_d, lat_inc;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic              ext_we_q, ext_we_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_data_q, dm_data_d;
  logic              pick_if;
  logic              idle;

  assign idle    = (state_q == IDLE);
  assign lat_inc = lat_q + CNT_W'(1);

  // Gated by rst so neither requester sees ready while reset is held.
  assign if_req_ready = rst && idle && if_req_valid && pick_if;
  assign dm_req_ready = rst && idle && dm_req_valid && !pick_if;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .if_valid(if_req_valid),
    .dm_valid(dm_req_valid),
    .grant_if(if_req_ready),
    .grant_dm(dm_req_ready),
    .pick_if (pick_if)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    ext_we_d    = 1'b0;
    we_d        = we_q;
    if_data_d   = if_data_q;
    dm_data_d   = dm_data_q;
    unique case (state_q)
      IDLE: begin
        if (if_req_ready) begin
          owner_d     = OWN_IF;
          ext_addr_d  = if_req_addr;
          ext_wdata_d = '0;
          we_d        = 1'b0;
          lat_d       = '0;
          state_d     = ACCESS;
        end else if (dm_req_ready) begin
          owner_d     = OWN_DM;
          ext_addr_d  = dm_req_addr;
          ext_wdata_d = dm_req_wdata;
          we_d        = dm_req_we;
          ext_we_d    = dm_req_we;
          lat_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        lat_d = lat_inc;
        if (lat_inc == CNT_W'(MEM_LAT)) begin
          if (owner_q == OWN_IF) begin
            if_data_d = ext_rdata;
          end else begin
            dm_data_d = we_q ? '0 : ext_rdata;
          end
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_we_q    <= 1'b0;
      we_q        <= 1'b0;
      if_data_q   <= '0;
      dm_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      ext_we_q    <= ext_we_d;
      we_q        <= we_d;
      if_data_q   <= if_data_d;
      dm_data_q   <= dm_data_d;
    end
  end

  assign ext_addr     = ext_addr_q;
  assign ext_wdata    = ext_wdata_q;
  assign ext_we       = ext_we_q;
  assign if_rsp_valid = (state_q == RESP) && (owner_q == OWN_IF);
  assign dm_rsp_valid = (state_q == RESP) && (owner_q == OWN_DM);
  assign if_rsp_data  = if_data_q;
  assign dm_rsp_data  = dm_data_q;
  assign busy         = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=1 main instance, MEM_LAT=4 timing instance).
module tb_mem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int RSP_LAT = 2;  // MEM_LAT + 1 for the main instance

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          if_req_valid, if_req_ready, if_rsp_valid;
  logic [AW-1:0] if_req_addr;
  logic [DW-1:0] if_rsp_data;
  logic          dm_req_valid, dm_req_we, dm_req_ready, dm_rsp_valid;
  logic [AW-1:0] dm_req_addr;
  logic [DW-1:0] dm_req_wdata, dm_rsp_data;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_we, busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
    .dm_req_wdata(dm_req_wdata), .dm_req_ready(dm_req_ready),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_rdata(ext_rdata),
    .busy(busy)
  );

  logic          l4_if_valid, l4_if_ready, l4_if_rsp_valid;
  logic [AW-1:0] l4_if_addr;
  logic [DW-1:0] l4_if_rsp_data;
  logic          l4_dm_valid, l4_dm_we, l4_dm_ready, l4_dm_rsp_valid;
  logic [AW-1:0] l4_dm_addr;
  logic [DW-1:0] l4_dm_wdata, l4_dm_rsp_data;
  logic [AW-1:0] l4_ext_addr;
  logic [DW-1:0] l4_ext_wdata, l4_ext_rdata;
  logic          l4_ext_we, l4_busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4), .STARVE_MAX(3)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_req_valid(l4_if_valid), .if_req_addr(l4_if_addr), .if_req_ready(l4_if_ready),
    .if_rsp_valid(l4_if_rsp_valid), .if_rsp_data(l4_if_rsp_data),
    .dm_req_valid(l4_dm_valid), .dm_req_we(l4_dm_we), .dm_req_addr(l4_dm_addr),
    .dm_req_wdata(l4_dm_wdata), .dm_req_ready(l4_dm_ready),
    .dm_rsp_valid(l4_dm_rsp_valid), .dm_rsp_data(l4_dm_rsp_data),
    .ext_addr(l4_ext_addr), .ext_wdata(l4_ext_wdata), .ext_we(l4_ext_we), .ext_rdata(l4_ext_rdata),
    .busy(l4_busy)
  );

  typedef struct {
    logic          is_dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
    int            t_acc;
  } exp_t;

  exp_t          sb[$];
  logic          grant_log[$];
  exp_t          mon_e, push_e;
  logic [DW-1:0] pad_mem [32];
  logic [DW-1:0] exp_mem [32];
  bit            mem_init = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            we_seen = 0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_dm = '0;

  assign ext_rdata = pad_mem[ext_addr];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pad model, scoreboard push on handshake, pop on response.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) begin
        pad_mem[i] = 16'h5A00 ^ (16'(i) * 16'h0101);
        exp_mem[i] = pad_mem[i];
      end
      pad_mem[3] = 16'hA5A5;
      exp_mem[3] = 16'hA5A5;
      mem_init = 1'b1;
    end
    if (rst) begin
      check_eq("ready_when_busy", busy && (if_req_ready || dm_req_ready), 0);
      if (ext_we) begin
        we_seen++;
        if (sb.size() == 0) begin
          check_eq("we_without_request", 1, 0);
        end else begin
          check_eq("we_cycle", cyc - sb[0].t_acc, 1);
          check_eq("we_is_write", sb[0].we, 1);
          check_eq("we_addr", ext_addr, sb[0].addr);
          check_eq("we_wdata", ext_wdata, sb[0].wdata);
        end
        pad_mem[ext_addr] = ext_wdata;
      end
      if (if_rsp_valid || dm_rsp_valid) begin
        check_eq("rsp_both", if_rsp_valid && dm_rsp_valid, 0);
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("rsp_owner", dm_rsp_valid, mon_e.is_dm);
          check_eq("rsp_latency", cyc - mon_e.t_acc, RSP_LAT);
          check_eq("rsp_data", mon_e.is_dm ? dm_rsp_data : if_rsp_data, mon_e.data);
          check_eq("we_count", we_seen, mon_e.we);
          if (mon_e.is_dm) last_dm = mon_e.data;
          else last_if = mon_e.data;
          if (mon_e.is_dm && mon_e.we) exp_mem[mon_e.addr] = mon_e.wdata;
        end
        we_seen = 0;
      end
      if (!if_rsp_valid) check_eq("if_rsp_hold", if_rsp_data, last_if);
      if (!dm_rsp_valid) check_eq("dm_rsp_hold", dm_rsp_data, last_dm);
      if (if_req_valid && if_req_ready) begin
        push_e.is_dm = 1'b0; push_e.we = 1'b0; push_e.addr = if_req_addr;
        push_e.wdata = '0; push_e.data = exp_mem[if_req_addr]; push_e.t_acc = cyc;
        sb.push_back(push_e);
        grant_log.push_back(1'b0);
      end
      if (dm_req_valid && dm_req_ready) begin
        push_e.is_dm = 1'b1; push_e.we = dm_req_we; push_e.addr = dm_req_addr;
        push_e.wdata = dm_req_wdata; push_e.data = dm_req_we ? '0 : exp_mem[dm_req_addr];
        push_e.t_acc = cyc;
        sb.push_back(push_e);
        grant_log.push_back(1'b1);
      end
    end
  end

  // All request tasks are entered 2 time units after a rising edge.
  task automatic dm_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
    int n = 0;
    dm_req_valid = 1'b1; dm_req_we = we; dm_req_addr = a; dm_req_wdata = d;
    do begin @(negedge clk); n++; end while (!dm_req_ready && n < 100);
    if (!dm_req_ready) check_eq("dm_grant_timeout", 0, 1);
    @(posedge clk); #2;
    if (drop) dm_req_valid = 1'b0;
  endtask

  task automatic if_req(input logic [AW-1:0] a, input bit drop);
    int n = 0;
    if_req_valid = 1'b1; if_req_addr = a;
    do begin @(negedge clk); n++; end while (!if_req_ready && n < 100);
    if (!if_req_ready) check_eq("if_grant_timeout", 0, 1);
    @(posedge clk); #2;
    if (drop) if_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || sb.size() != 0) && n < 50);
    if (busy || sb.size() != 0) check_eq("idle_timeout", 1, 0);
    @(posedge clk); #2;
  endtask

  // Expected grant order with both requesters held valid: D D D I D D D I.
  task automatic contention(input int nd, input int ni);
    logic [7:0] pat;
    pat = 8'b1110_1110;
    grant_log.delete();
    fork
      for (int i = 0; i < nd; i++)
        dm_req(i[0], AW'($urandom_range(0, 31)), DW'($urandom), i == nd - 1);
      for (int j = 0; j < ni; j++)
        if_req(AW'($urandom_range(0, 31)), j == ni - 1);
    join
    wait_idle();
    check_eq("grant_count", grant_log.size(), nd + ni);
    for (int k = 0; k < nd + ni && k < int'(grant_log.size()); k++)
      check_eq("grant_order", grant_log[k], pat[7-k]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if_req_valid = 1'b1; if_req_addr = '0;
    dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = '0; dm_req_wdata = '0;
    l4_if_valid = 1'b0; l4_if_addr = '0;
    l4_dm_valid = 1'b0; l4_dm_we = 1'b0; l4_dm_addr = '0; l4_dm_wdata = '0;
    l4_ext_rdata = 16'hDEAD;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_if_ready", if_req_ready, 0);
    check_eq("rst_dm_ready", dm_req_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ext_we", ext_we, 0);
    check_eq("rst_ext_addr", ext_addr, 0);
    check_eq("rst_ext_wdata", ext_wdata, 0);
    check_eq("rst_if_rsp_valid", if_rsp_valid, 0);
    check_eq("rst_dm_rsp_valid", dm_rsp_valid, 0);
    check_eq("rst_if_rsp_data", if_rsp_data, 0);
    check_eq("rst_dm_rsp_data", dm_rsp_data, 0);
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;

    if_req(5'h03, 1'b1);
    wait_idle();
    dm_req(1'b1, 5'h1F, 16'h1234, 1'b1);
    wait_idle();
    dm_req(1'b0, 5'h1F, '0, 1'b1);
    wait_idle();

    contention(6, 2);

    // Fetch valid pulsed while the port is busy must not start a transaction.
    dm_req(1'b0, 5'h05, '0, 1'b1);
    if_req_valid = 1'b1; if_req_addr = 5'h09;
    @(negedge clk);
    check_eq("if_ready_in_access", if_req_ready, 0);
    check_eq("busy_in_access", busy, 1);
    @(posedge clk); #2;
    if_req_valid = 1'b0;
    wait_idle();
    contention(3, 1);

    // Reset during the write strobe cycle discards the write.
    dm_req(1'b1, 5'h0A, 16'hCAFE, 1'b0);
    check_eq("pre_rst_ext_we", ext_we, 1);
    rst = 1'b0;
    if_req_valid = 1'b1;
    #1;
    check_eq("mid_rst_ext_we", ext_we, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ext_addr", ext_addr, 0);
    check_eq("mid_rst_ext_wdata", ext_wdata, 0);
    check_eq("mid_rst_dm_rsp_valid", dm_rsp_valid, 0);
    check_eq("mid_rst_if_rsp_data", if_rsp_data, 0);
    check_eq("mid_rst_dm_rsp_data", dm_rsp_data, 0);
    check_eq("mid_rst_if_ready", if_req_ready, 0);
    check_eq("mid_rst_dm_ready", dm_req_ready, 0);
    sb.delete();
    we_seen = 0;
    last_if = '0;
    last_dm = '0;
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    dm_req(1'b0, 5'h0A, '0, 1'b1);
    wait_idle();

    // MEM_LAT=4 instance: data only correct in the sampling cycle T+4.
    l4_dm_valid = 1'b1; l4_dm_we = 1'b0; l4_dm_addr = 5'h07;
    @(negedge clk);
    check_eq("l4_accept_ready", l4_dm_ready, 1);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #2;
      l4_ext_rdata = (c == 4) ? 16'hBEEF : 16'hDEAD;
      @(negedge clk);
      if (c == 1) check_eq("l4_ext_addr", l4_ext_addr, 5'h07);
      if (c <= 5) check_eq("l4_ready_blocked", l4_dm_ready, 0);
      check_eq("l4_rsp_valid", l4_dm_rsp_valid, c == 5);
      if (c == 5) check_eq("l4_rsp_data", l4_dm_rsp_data, 16'hBEEF);
      if (c == 6) check_eq("l4_ready_again", l4_dm_ready, 1);
    end
    @(posedge clk); #2;
    l4_dm_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    check_eq("l4_idle_end", l4_busy, 0);

    check_eq("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one off-chip 16-bit memory port between the pipelined core's instruction-fetch requester and its data-memory (load/store) requester, so a single pad set serves both. It sits between the core and the pad ring. It serialises requests with a fixed-priority-plus-anti-starvation arbiter and sequences each access through a fixed-latency external memory. It returns read data, or a write acknowledge, to the requester that issued the access.

## Interface
- ADDR_W, 5, external/requester address width
- DATA_W, 16, data width
- MEM_LAT, 1, external read latency in cycles (legal 1..4)
- STARVE_MAX, 3, consecutive lost arbitrations after which fetch wins

- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDR_W  fetch address
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  one-cycle pulse, fetch data valid
- if_rsp_data  out  DATA_W  fetched word
- dm_req_valid  in  1  data request
- dm_req_we  in  1  1 = write, 0 = read
- dm_req_addr  in  ADDR_W  data address
- dm_req_wdata  in  DATA_W  write data
- dm_req_ready  out  1  data request accepted this cycle
- dm_rsp_valid  out  1  one-cycle pulse, read data or write ack
- dm_rsp_data  out  DATA_W  read word (0 on write ack)
- ext_addr  out  ADDR_W  registered address to memory pads
- ext_wdata  out  DATA_W  registered write data to pads
- ext_we  out  1  registered write enable to pads
- ext_rdata  in  DATA_W  read data from pads
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - Winner is dm if dm_req_valid and starve_cnt < STARVE_MAX.
  - Otherwise the winner is fetch if if_req_valid.
  - Otherwise dm if dm_req_valid.
  - Ready is asserted combinationally to the winner only. On ready&valid, latch owner, address, we and wdata into the ext_* registers, clear the latency counter, and go to ACCESS.
- Ready is never asserted outside IDLE. A requester may drop valid before ready; no transaction results.
- starve_cnt rules:
  - Increments (saturating at STARVE_MAX) in any IDLE cycle where if_req_valid=1 and dm wins.
  - Clears on a fetch grant or any cycle with if_req_valid=0.
- ACCESS:
  - ext_addr/ext_wdata hold.
  - ext_we=1 only in the first ACCESS cycle of a write, 0 otherwise.
  - Counter increments each cycle. When it reaches MEM_LAT, sample ext_rdata (reads) into the response register and go to RESP.
- RESP: pulse the owner's rsp_valid for exactly one cycle; rsp_data holds the sampled word (0 for write ack); go to IDLE.
- The non-owner's rsp_valid stays 0. rsp_data holds its last value between pulses.
- Simultaneous requests in IDLE are resolved by the rules above; the loser holds valid and retries next IDLE.

## Timing
- Accept cycle T (IDLE, ready&valid).
- ACCESS spans T+1..T+MEM_LAT; ext_* valid from T+1. Write strobe occurs at T+1.
- ext_rdata is sampled at the end of T+MEM_LAT; rsp_valid is high in T+MEM_LAT+1.
- Next accept is no earlier than T+MEM_LAT+2; peak throughput is one access per MEM_LAT+2 cycles.
- Reset values: state IDLE, ext_addr 0, ext_wdata 0, ext_we 0, both rsp_valid 0, both rsp_data 0, starve_cnt 0, busy 0. Both ready are 0 while rst=0.
- Reset mid-access: ext_we drops immediately (asynchronous), the transaction is discarded, and no rsp_valid follows.
- Counter width is clog2(MEM_LAT+1); no wrap occurs within an access.

## Structure
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - owner enum {OWN_IF, OWN_DM}
  - default ADDR_W/DATA_W constants
- Sub-module mem_arb_starve_ctr: saturating starvation counter plus winner select (inputs if_valid, dm_valid, grant_if, grant_dm; output pick_if).
- Top: FSM, latency counter, ext_* and response registers.

## Test plan
- Fetch read: if_req addr 5'h03, ext_rdata=16'hA5A5 at T+MEM_LAT -> if_rsp_valid one cycle at T+2 (MEM_LAT=1) with 16'hA5A5, dm_rsp_valid stays 0.
- Data write: dm_req we=1, addr 5'h1F, wdata 16'h1234 -> ext_we high exactly at T+1 with ext_addr 5'h1F and ext_wdata 16'h1234; dm_rsp_valid at T+2 with data 0.
- Contention: both valid continuously (STARVE_MAX=3) -> grant order dm, dm, dm, if, dm, dm, dm, if.
- Latency sweep MEM_LAT=4: read at accept T -> ext_rdata sampled at T+4, rsp_valid at T+5, next ready no earlier than T+6.
- Reset mid-write: assert rst=0 during ACCESS -> ext_we 0 immediately, all outputs at reset values; after release, no stale rsp_valid and the next request completes normally.
- Valid withdrawn: if_req_valid pulses for one cycle while the FSM is in ACCESS -> no fetch transaction, starve_cnt back to 0.
